// File: rtl/arrow_scroll.sv
// Lane-based scrolling-arrow game core: arrows rise from SPAWN_Y toward a
// target line, the player presses a lane button while the arrow is inside
// the hit window, and arrows that pass the window count as misses.
module arrow_scroll #(
  parameter int CORDW       = 10,
  parameter int ARROW_COUNT = 3,
  parameter int SPAWN_Y     = 470,
  parameter int TARGET_Y    = 40,
  parameter int HIT_WINDOW  = 6,
  parameter int SPEED       = 2,
  parameter int MISS_LIMIT  = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         frame_i,
  input  logic [ARROW_COUNT-1:0]       spawn_i,
  input  logic [ARROW_COUNT-1:0]       btn_i,
  output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
  output logic [ARROW_COUNT-1:0]       arrow_active_o,
  output logic [ARROW_COUNT-1:0]       hit_o,
  output logic [ARROW_COUNT-1:0]       miss_o,
  output logic [15:0]                  score_o,
  output logic                         running_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam logic [CORDW-1:0] LOW_Y     = CORDW'(TARGET_Y - HIT_WINDOW);
  localparam logic [CORDW-1:0] HIGH_Y    = CORDW'(TARGET_Y + HIT_WINDOW);
  localparam logic [CORDW-1:0] SPAWN_VAL = CORDW'(SPAWN_Y);
  localparam logic [CORDW-1:0] STEP      = CORDW'(SPEED);
  localparam logic [CORDW-1:0] NO_ARROW  = '1;

  localparam int              MCW      = $clog2(MISS_LIMIT + 1);
  localparam logic [MCW-1:0]  MISS_MAX = MCW'(MISS_LIMIT);

  // The move-then-compare below must never wrap below zero.
  generate
    if (TARGET_Y - HIT_WINDOW < SPEED) begin : g_bad_params
      $error("arrow_scroll: TARGET_Y - HIT_WINDOW must be >= SPEED");
    end
  endgenerate

  logic [1:0]             state_q, state_d;
  logic [CORDW-1:0]       y_q [ARROW_COUNT];
  logic [CORDW-1:0]       y_d [ARROW_COUNT];
  logic [ARROW_COUNT-1:0] active_q, active_d;
  logic [ARROW_COUNT-1:0] pending_q, pending_d;
  logic [ARROW_COUNT-1:0] hit_q, hit_d;
  logic [ARROW_COUNT-1:0] miss_q, miss_d;
  logic [15:0]            score_q, score_d;
  logic [MCW-1:0]         miss_cnt_q, miss_cnt_d;

  // Game phase: start launches or restarts a game, a full miss counter ends it
  // one cycle after it fills.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (miss_cnt_q == MISS_MAX) state_d = ST_OVER;
      ST_OVER: if (start_i) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane update: hits take priority over frame movement, expired arrows turn
  // into misses, and free lanes pick up a pending spawn on the frame tick.
  always_comb begin
    logic [CORDW-1:0] y_mv;
    logic [16:0]      score_sum;
    int               hit_total;
    int               miss_total;
    int               miss_sum;

    y_mv       = '0;
    score_sum  = '0;
    hit_total  = 0;
    miss_total = 0;
    miss_sum   = 0;
    for (int k = 0; k < ARROW_COUNT; k++) y_d[k] = y_q[k];
    active_d   = active_q;
    pending_d  = pending_q;
    hit_d      = '0;
    miss_d     = '0;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;

    if (state_q != ST_RUN && state_d == ST_RUN) begin
      for (int k = 0; k < ARROW_COUNT; k++) y_d[k] = NO_ARROW;
      active_d   = '0;
      pending_d  = '0;
      score_d    = '0;
      miss_cnt_d = '0;
    end else if (state_q == ST_RUN && state_d == ST_OVER) begin
      for (int k = 0; k < ARROW_COUNT; k++) y_d[k] = NO_ARROW;
      active_d  = '0;
      pending_d = '0;
    end else if (state_q == ST_RUN) begin
      for (int k = 0; k < ARROW_COUNT; k++) begin
        if (btn_i[k] && active_q[k] && y_q[k] >= LOW_Y && y_q[k] <= HIGH_Y) begin
          active_d[k] = 1'b0;
          y_d[k]      = NO_ARROW;
          hit_d[k]    = 1'b1;
          hit_total   = hit_total + 1;
        end else if (frame_i) begin
          if (active_q[k]) begin
            y_mv = y_q[k] - STEP;
            if (y_mv < LOW_Y) begin
              active_d[k] = 1'b0;
              y_d[k]      = NO_ARROW;
              miss_d[k]   = 1'b1;
              miss_total  = miss_total + 1;
            end else begin
              y_d[k] = y_mv;
            end
          end else if (pending_q[k]) begin
            active_d[k]  = 1'b1;
            y_d[k]       = SPAWN_VAL;
            pending_d[k] = 1'b0;
          end
        end
        if (spawn_i[k]) pending_d[k] = 1'b1;
      end

      score_sum = {1'b0, score_q} + 17'(hit_total);
      score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

      miss_sum = int'(miss_cnt_q) + miss_total;
      miss_cnt_d = (miss_sum >= MISS_LIMIT) ? MISS_MAX : MCW'(miss_sum);
    end
  end

  // All game state and output pulses are registered; reset forces the idle
  // picture immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      for (int k = 0; k < ARROW_COUNT; k++) y_q[k] <= NO_ARROW;
      active_q   <= '0;
      pending_q  <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      score_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      for (int k = 0; k < ARROW_COUNT; k++) y_q[k] <= y_d[k];
      active_q   <= active_d;
      pending_q  <= pending_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  generate
    for (genvar k = 0; k < ARROW_COUNT; k++) begin : g_lane_out
      assign arrow_y_o[CORDW*k +: CORDW] = y_q[k];
    end
  endgenerate

  assign arrow_active_o = active_q;
  assign hit_o          = hit_q;
  assign miss_o         = miss_q;
  assign score_o        = score_q;
  assign running_o      = (state_q == ST_RUN);

endmodule

// File: tb/tb_arrow_scroll.sv
// Directed and randomized checks of arrow_scroll against a game-rule model.
module tb_arrow_scroll;

  localparam int CORDW      = 10;
  localparam int NL         = 3;
  localparam int SPAWN_Y    = 470;
  localparam int TARGET_Y   = 40;
  localparam int HIT_WINDOW = 6;
  localparam int SPEED      = 2;
  localparam int MISS_LIMIT = 3;

  typedef enum {M_IDLE, M_RUN, M_OVER} mode_t;

  logic                  clk_i;
  logic                  rst_ni;
  logic                  start_i;
  logic                  frame_i;
  logic [NL-1:0]         spawn_i;
  logic [NL-1:0]         btn_i;
  logic [CORDW*NL-1:0]   arrow_y_o;
  logic [NL-1:0]         arrow_active_o;
  logic [NL-1:0]         hit_o;
  logic [NL-1:0]         miss_o;
  logic [15:0]           score_o;
  logic                  running_o;

  int vectors    = 0;
  int miscompares = 0;

  mode_t   m_mode;
  int      m_y     [NL];
  bit      m_act   [NL];
  bit      m_pend  [NL];
  bit [NL-1:0] m_hit;
  bit [NL-1:0] m_miss;
  int      m_score;
  int      m_misses;

  arrow_scroll #(
    .CORDW(CORDW), .ARROW_COUNT(NL), .SPAWN_Y(SPAWN_Y), .TARGET_Y(TARGET_Y),
    .HIT_WINDOW(HIT_WINDOW), .SPEED(SPEED), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .frame_i(frame_i),
    .spawn_i(spawn_i), .btn_i(btn_i), .arrow_y_o(arrow_y_o),
    .arrow_active_o(arrow_active_o), .hit_o(hit_o), .miss_o(miss_o),
    .score_o(score_o), .running_o(running_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic clearLanes();
    for (int k = 0; k < NL; k++) begin
      m_act[k]  = 1'b0;
      m_pend[k] = 1'b0;
      m_y[k]    = 0;
    end
  endtask

  task automatic modelReset();
    m_mode   = M_IDLE;
    clearLanes();
    m_hit    = '0;
    m_miss   = '0;
    m_score  = 0;
    m_misses = 0;
  endtask

  // One clock of game rules, applied to the inputs present before the edge.
  task automatic modelStep(input bit st, input bit fr, input bit [NL-1:0] sp, input bit [NL-1:0] bt);
    m_hit  = '0;
    m_miss = '0;
    if (m_mode != M_RUN) begin
      if (st) begin
        m_mode   = M_RUN;
        m_score  = 0;
        m_misses = 0;
        clearLanes();
      end
    end else if (m_misses >= MISS_LIMIT) begin
      m_mode = M_OVER;
      clearLanes();
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (bt[k] && m_act[k] && m_y[k] >= TARGET_Y - HIT_WINDOW && m_y[k] <= TARGET_Y + HIT_WINDOW) begin
          m_act[k] = 1'b0;
          m_hit[k] = 1'b1;
          if (m_score < 65535) m_score++;
        end else if (fr) begin
          if (m_act[k]) begin
            if (m_y[k] - SPEED < TARGET_Y - HIT_WINDOW) begin
              m_act[k]  = 1'b0;
              m_miss[k] = 1'b1;
              if (m_misses < MISS_LIMIT) m_misses++;
            end else begin
              m_y[k] = m_y[k] - SPEED;
            end
          end else if (m_pend[k]) begin
            m_act[k]  = 1'b1;
            m_y[k]    = SPAWN_Y;
            m_pend[k] = 1'b0;
          end
        end
        if (sp[k]) m_pend[k] = 1'b1;
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model, and lands 1 ns past the edge.
  task automatic applyStimulus(input bit st, input bit fr, input bit [NL-1:0] sp, input bit [NL-1:0] bt);
    start_i = st;
    frame_i = fr;
    spawn_i = sp;
    btn_i   = bt;
    modelStep(st, fr, sp, bt);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    frame_i = 1'b0;
    spawn_i = '0;
    btn_i   = '0;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compares every output against the model.
  task automatic checkOutput(input string tag);
    logic [CORDW*NL-1:0] exp_y;
    logic [NL-1:0]       exp_act;
    for (int k = 0; k < NL; k++) begin
      exp_y[CORDW*k +: CORDW] = m_act[k] ? CORDW'(m_y[k]) : '1;
      exp_act[k]              = m_act[k];
    end
    vectors++;
    assert (arrow_y_o === exp_y) else begin
      miscompares++;
      $error("[TB] FAIL %s arrow_y observed=%h expected=%h", tag, arrow_y_o, exp_y);
    end
    vectors++;
    assert (arrow_active_o === exp_act) else begin
      miscompares++;
      $error("[TB] FAIL %s active observed=%b expected=%b", tag, arrow_active_o, exp_act);
    end
    vectors++;
    assert (hit_o === m_hit) else begin
      miscompares++;
      $error("[TB] FAIL %s hit observed=%b expected=%b", tag, hit_o, m_hit);
    end
    vectors++;
    assert (miss_o === m_miss) else begin
      miscompares++;
      $error("[TB] FAIL %s miss observed=%b expected=%b", tag, miss_o, m_miss);
    end
    vectors++;
    assert (score_o === 16'(m_score)) else begin
      miscompares++;
      $error("[TB] FAIL %s score observed=%0d expected=%0d", tag, score_o, m_score);
    end
    vectors++;
    assert (running_o === (m_mode == M_RUN)) else begin
      miscompares++;
      $error("[TB] FAIL %s running observed=%b expected=%b", tag, running_o, (m_mode == M_RUN));
    end
  endtask

  task automatic frames(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, '0, '0);
      checkOutput(tag);
    end
  endtask

  initial begin
    bit          st, fr;
    bit [NL-1:0] sp, bt;

    rst_ni  = 1'b1;
    start_i = 1'b0;
    frame_i = 1'b0;
    spawn_i = '0;
    btn_i   = '0;
    #2 rst_ni = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    checkOutput("reset_held");
    checkValue("reset_y", {2'b0, arrow_y_o}, 32'h3FFF_FFFF);
    rst_ni = 1'b1;

    // Inputs other than start are ignored while idle.
    applyStimulus(1'b0, 1'b1, 3'b111, 3'b111);
    checkOutput("idle_ignore");

    // First arrow appears at the spawn line on the next frame.
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("start");
    applyStimulus(1'b0, 1'b0, 3'b001, '0);
    checkOutput("spawn_req");
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("spawn_frame");
    checkValue("spawn_y", {2'b0, arrow_y_o}, {2'b0, 10'd1023, 10'd1023, 10'd470});

    // Lane 0 rides up to y=34 and misses on the following frame.
    frames(218, "rise0");
    checkValue("y34", 32'(arrow_y_o[9:0]), 32'd34);
    checkValue("no_miss_34", 32'(miss_o), 32'd0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("miss0");
    checkValue("miss0_pulse", 32'(miss_o), 32'b001);
    checkValue("miss0_y", 32'(arrow_y_o[9:0]), 32'd1023);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("miss0_end");

    // Lane 1 hit at the top edge of the window.
    applyStimulus(1'b0, 1'b0, 3'b010, '0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("spawn1");
    frames(212, "rise1");
    checkValue("y46", 32'(arrow_y_o[19:10]), 32'd46);
    applyStimulus(1'b0, 1'b0, '0, 3'b010);
    checkOutput("hit1");
    checkValue("hit1_pulse", 32'(hit_o), 32'b010);
    checkValue("hit1_score", 32'(score_o), 32'd1);

    // Press just above the window does nothing; the arrow keeps moving.
    applyStimulus(1'b0, 1'b0, 3'b010, '0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    frames(211, "rise1b");
    checkValue("y48", 32'(arrow_y_o[19:10]), 32'd48);
    applyStimulus(1'b0, 1'b0, '0, 3'b010);
    checkOutput("early_press");
    checkValue("early_nohit", 32'(hit_o), 32'd0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("keeps_moving");
    checkValue("y46b", 32'(arrow_y_o[19:10]), 32'd46);
    applyStimulus(1'b0, 1'b0, '0, 3'b010);
    checkOutput("hit1b");

    // Lanes 0 and 2 hit at the target line in a frame cycle.
    applyStimulus(1'b0, 1'b0, 3'b101, '0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    frames(215, "rise02");
    checkValue("y40", {2'b0, arrow_y_o}, {2'b0, 10'd40, 10'd1023, 10'd40});
    applyStimulus(1'b0, 1'b1, '0, 3'b101);
    checkOutput("hit02");
    checkValue("hit02_pulse", 32'(hit_o), 32'b101);
    checkValue("hit02_miss", 32'(miss_o), 32'd0);
    checkValue("hit02_score", 32'(score_o), 32'd4);

    // Three simultaneous misses end the game one cycle later.
    applyStimulus(1'b0, 1'b0, 3'b111, '0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    frames(219, "rise_all");
    checkValue("miss_all", 32'(miss_o), 32'b111);
    checkValue("still_running", 32'(running_o), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("over");
    checkValue("over_running", 32'(running_o), 32'd0);
    checkValue("over_score", 32'(score_o), 32'd4);
    applyStimulus(1'b0, 1'b0, 3'b111, '0);
    checkOutput("over_spawn");
    applyStimulus(1'b0, 1'b1, '0, 3'b111);
    checkOutput("over_frame");

    // Restart clears score and lanes.
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("restart");
    checkValue("restart_score", 32'(score_o), 32'd0);
    checkValue("restart_y", {2'b0, arrow_y_o}, 32'h3FFF_FFFF);
    applyStimulus(1'b1, 1'b0, 3'b011, '0);
    checkOutput("start_in_run");
    frames(5, "pre_reset");

    // Short asynchronous reset pulse between clock edges.
    #2 rst_ni = 1'b0;
    modelReset();
    #1;
    checkOutput("mid_reset");
    #2 rst_ni = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'b111, '0);
    checkOutput("post_reset");
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("post_reset_idle");
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("resume");

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, 499) == 0);
      fr = ($urandom_range(0, 1) == 1);
      sp = (!fr && $urandom_range(0, 9) == 0) ? NL'($urandom) : '0;
      bt = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
      applyStimulus(st, fr, sp, bt);
      checkOutput("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
